bp_l15_req_arbiter: RTL

//  Shares the single OpenPiton L1.5 request/return channel between num_req_p BP-side transducers
//  (req 0 = I$ transducer, req 1 = D$ transducer). Round-robin grant, one L1.5 transaction

---
 rtl/bp_l15_req_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/bp_l15_req_arbiter.sv
// Purpose: shares one L1.5 request/return channel between num_req_p transducers, round-robin, one transaction in flight.
// Latency: grant is registered (L1.5 sees a request 1 cycle after req_val_i); returns are steered combinationally.
// Backpressure: requests hold until l15_transducer_ack; returns hold until the owner (or all, for INT) acks.
module bp_l15_req_arbiter #(
  parameter int num_req_p = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic [num_req_p-1:0]     req_val_i,
  input  logic [5*num_req_p-1:0]   req_rqtype_i,
  input  logic [num_req_p-1:0]     req_nc_i,
  input  logic [3*num_req_p-1:0]   req_size_i,
  input  logic [40*num_req_p-1:0]  req_address_i,
  input  logic [64*num_req_p-1:0]  req_data_i,
  input  logic [2*num_req_p-1:0]   req_l1rplway_i,
  output logic [num_req_p-1:0]     req_ack_o,

  output logic [num_req_p-1:0]     resp_val_o,
  output logic [3:0]               resp_returntype_o,
  output logic [63:0]              resp_data_0_o,
  output logic [63:0]              resp_data_1_o,
  input  logic [num_req_p-1:0]     resp_ack_i,

  output logic                     transducer_l15_val,
  output logic [4:0]               transducer_l15_rqtype,
  output logic                     transducer_l15_nc,
  output logic [2:0]               transducer_l15_size,
  output logic [39:0]              transducer_l15_address,
  output logic [63:0]              transducer_l15_data,
  output logic [1:0]               transducer_l15_l1rplway,
  input  logic                     l15_transducer_ack,

  input  logic                     l15_transducer_val,
  input  logic [3:0]               l15_transducer_returntype,
  input  logic [63:0]              l15_transducer_data_0,
  input  logic [63:0]              l15_transducer_data_1,
  output logic                     transducer_l15_req_ack,

  output logic                     unexpected_ret_o
);

  localparam int lg_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  localparam logic [1:0] e_idle = 2'd0;
  localparam logic [1:0] e_send = 2'd1;
  localparam logic [1:0] e_wait = 2'd2;

  localparam logic [3:0] int_ret_lp = 4'b0111;

  logic [1:0]           state_r;
  logic [lg_req_lp-1:0] owner_r;
  logic [lg_req_lp-1:0] rr_ptr_r;
  logic [num_req_p-1:0] int_seen_r;
  logic                 unexpected_r;

  logic [lg_req_lp-1:0] pick;
  logic [lg_req_lp-1:0] idx;
  logic                 pick_vld;
  logic                 int_ret;
  logic                 norm_ret;
  logic                 int_fire;
  logic [lg_req_lp-1:0] rr_next;

  assign int_ret  = l15_transducer_val && (l15_transducer_returntype == int_ret_lp);
  assign norm_ret = l15_transducer_val && (l15_transducer_returntype != int_ret_lp);
  assign int_fire = int_ret && (&(int_seen_r | resp_ack_i));
  assign rr_next  = (int'(owner_r) == num_req_p - 1) ? '0 : owner_r + 1'b1;

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping; lowest offset wins.
  always_comb begin
    pick     = '0;
    idx      = '0;
    pick_vld = 1'b0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      idx = lg_req_lp'((int'(rr_ptr_r) + k) % num_req_p);
      if (req_val_i[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Output steering; everything is forced low while reset is asserted.
  always_comb begin
    req_ack_o               = '0;
    resp_val_o              = '0;
    resp_returntype_o       = '0;
    resp_data_0_o           = '0;
    resp_data_1_o           = '0;
    transducer_l15_val      = 1'b0;
    transducer_l15_rqtype   = '0;
    transducer_l15_nc       = 1'b0;
    transducer_l15_size     = '0;
    transducer_l15_address  = '0;
    transducer_l15_data     = '0;
    transducer_l15_l1rplway = '0;
    transducer_l15_req_ack  = 1'b0;
    unexpected_ret_o        = 1'b0;
    if (reset_n_i) begin
      resp_returntype_o = l15_transducer_returntype;
      resp_data_0_o     = l15_transducer_data_0;
      resp_data_1_o     = l15_transducer_data_1;
      unexpected_ret_o  = unexpected_r;
      if (state_r == e_send) begin
        transducer_l15_val      = req_val_i[owner_r];
        transducer_l15_rqtype   = req_rqtype_i[5*int'(owner_r) +: 5];
        transducer_l15_nc       = req_nc_i[owner_r];
        transducer_l15_size     = req_size_i[3*int'(owner_r) +: 3];
        transducer_l15_address  = req_address_i[40*int'(owner_r) +: 40];
        transducer_l15_data     = req_data_i[64*int'(owner_r) +: 64];
        transducer_l15_l1rplway = req_l1rplway_i[2*int'(owner_r) +: 2];
        req_ack_o[owner_r]      = l15_transducer_ack;
      end
      if (int_ret) begin
        // Interrupts go to everyone; the L1.5 is released once each requester has taken it.
        resp_val_o             = ~int_seen_r;
        transducer_l15_req_ack = int_fire;
      end else if (norm_ret) begin
        if (state_r == e_wait) begin
          resp_val_o[owner_r]    = 1'b1;
          transducer_l15_req_ack = resp_ack_i[owner_r];
        end else begin
          // Nobody owns this return: drain it so the L1.5 cannot stall.
          transducer_l15_req_ack = 1'b1;
        end
      end
    end
  end

  // Arbitration state, interrupt bookkeeping and the sticky unowned-return flag.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r      <= e_idle;
      owner_r      <= '0;
      rr_ptr_r     <= '0;
      int_seen_r   <= '0;
      unexpected_r <= 1'b0;
    end else begin
      if (int_ret) begin
        int_seen_r <= int_fire ? '0 : (int_seen_r | resp_ack_i);
      end
      if (norm_ret && (state_r != e_wait)) begin
        unexpected_r <= 1'b1;
      end
      case (state_r)
        e_idle: begin
          if (pick_vld && !int_ret) begin
            owner_r <= pick;
            state_r <= e_send;
          end
        end
        e_send: begin
          if (l15_transducer_ack) begin
            state_r <= e_wait;
          end
        end
        e_wait: begin
          if (norm_ret && resp_ack_i[owner_r]) begin
            state_r  <= e_idle;
            rr_ptr_r <= rr_next;
          end
        end
        default: state_r <= e_idle;
      endcase
    end
  end

endmodule
